// File: rtl/cache_pmem_arbiter.sv
// rtl/cache_pmem_arbiter.sv - arbitrates I-cache and D-cache line traffic onto one physical memory port
// Optional ARB_ROUND_ROBIN_EN: round-robin tie break instead of fixed D-first priority.
module cache_pmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D_RD,
        GRANT_D_WR
    } state_t;

    state_t state;
    logic   i_req;
    logic   d_req;
    logic   pick_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the I-cache was served last; resets set so the D-cache wins the first tie.
    logic last_i;
    assign pick_d = d_req & (~i_req | last_i);
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_i      <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        mem_address <= d_pmem_address;
`ifdef ARB_ROUND_ROBIN_EN
                        last_i      <= 1'b0;
`endif
                        // A simultaneous read+write is a write-back; the fill follows later.
                        if (d_pmem_write) begin
                            state     <= GRANT_D_WR;
                            mem_write <= 1'b1;
                            mem_wdata <= d_pmem_wdata;
                        end else begin
                            state    <= GRANT_D_RD;
                            mem_read <= 1'b1;
                        end
                    end else if (i_req) begin
                        state       <= GRANT_I;
                        mem_read    <= 1'b1;
                        mem_address <= i_pmem_address;
`ifdef ARB_ROUND_ROBIN_EN
                        last_i      <= 1'b1;
`endif
                    end
                end
                default: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign i_pmem_resp  = (state == GRANT_I) & mem_resp;
    assign d_pmem_resp  = ((state == GRANT_D_RD) | (state == GRANT_D_WR)) & mem_resp;
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// tb/tb_cache_pmem_arbiter.sv - self-checking bench for cache_pmem_arbiter
module tb_cache_pmem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int K_NONE = 0;
    localparam int K_I    = 1;
    localparam int K_DR   = 2;
    localparam int K_DW   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_pmem_read = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [AW-1:0] d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_resp = 1'b0;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    int resp_mode = 0;
    int fixed_lat = 1;
    bit rand_lat = 1'b0;

    cache_pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkl(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the transaction currently owning memory, and who was served last.
    int            cur = K_NONE;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_wdata = '0;
    int            age = 0;
    int            cur_lat = 0;
    bit            served_i_last = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cur = K_NONE;
            m_addr = '0;
            m_wdata = '0;
            age = 0;
            served_i_last = 1'b1;
        end else if (cur != K_NONE) begin
            if (mem_resp) cur = K_NONE;
            else age++;
        end else begin
            bit dq, iq, win_d;
            dq = d_pmem_read | d_pmem_write;
            iq = i_pmem_read;
            win_d = (dq && iq) ? (RR ? served_i_last : 1'b1) : dq;
            if (dq || iq) begin
                if (win_d) begin
                    cur = d_pmem_write ? K_DW : K_DR;
                    m_addr = d_pmem_address;
                    if (d_pmem_write) m_wdata = d_pmem_wdata;
                end else begin
                    cur = K_I;
                    m_addr = i_pmem_address;
                end
                served_i_last = !win_d;
                age = 0;
                cur_lat = rand_lat ? int'($urandom_range(0, 4)) : fixed_lat;
            end
        end
    end

    logic exp_read, exp_write, exp_i_resp, exp_d_resp;
    assign exp_read   = (cur == K_I) || (cur == K_DR);
    assign exp_write  = (cur == K_DW);
    assign exp_i_resp = (cur == K_I) && mem_resp;
    assign exp_d_resp = ((cur == K_DR) || (cur == K_DW)) && mem_resp;

    // Memory responder: answers after the chosen latency, optionally with spurious idle responses.
    always @(posedge clk) begin
        #1;
        if (resp_mode != 2) begin
            if (cur == K_NONE) mem_resp = (resp_mode == 1) && (($urandom % 6) == 0);
            else mem_resp = (age >= cur_lat);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk1("mem_read", mem_read, exp_read);
            chk1("mem_write", mem_write, exp_write);
            chk1("i_pmem_resp", i_pmem_resp, exp_i_resp);
            chk1("d_pmem_resp", d_pmem_resp, exp_d_resp);
            chka("mem_address", mem_address, m_addr);
            chkl("mem_wdata", mem_wdata, m_wdata);
            chkl("i_pmem_rdata", i_pmem_rdata, mem_rdata);
            chkl("d_pmem_rdata", d_pmem_rdata, mem_rdata);
        end
    end

    // Runs until n responses are seen; grant order is encoded base-4 (D=1, I=2).
    task automatic collect(input int n, input bit drop, output int seq);
        int got;
        got = 0;
        seq = 0;
        for (int c = 0; c < 200 && got < n; c++) begin
            bit gd, gi;
            @(negedge clk);
            gd = d_pmem_resp;
            gi = i_pmem_resp;
            if (gd) begin seq = seq * 4 + 1; got++; end
            if (gi) begin seq = seq * 4 + 2; got++; end
            @(posedge clk); #1;
            if (drop && gd) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
            if (drop && gi) i_pmem_read = 1'b0;
        end
        chki("collect_count", got, n);
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        int seq;
        logic [LW-1:0] pat_rd;
        logic [LW-1:0] pat_a5;
        pat_rd = {8{32'h1234_5678}};
        pat_a5 = {32{8'hA5}};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chka("rst_mem_address", mem_address, 32'h0);
        chkl("rst_mem_wdata", mem_wdata, '0);
        chk1("rst_i_resp", i_pmem_resp, 1'b0);
        chk1("rst_d_resp", d_pmem_resp, 1'b0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Single I-cache read, memory answers in the fourth grant cycle.
        fixed_lat = 3;
        mem_rdata = pat_rd;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_1000;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            chk1("t1_mem_read", mem_read, (c >= 1 && c <= 4));
            chk1("t1_model_read", exp_read, (c >= 1 && c <= 4));
            chk1("t1_i_resp", i_pmem_resp, (c == 4));
            if (c == 4) chkl("t1_rdata", i_pmem_rdata, pat_rd);
            if (c == 1) chka("t1_addr", mem_address, 32'h0000_1000);
            next_cycle();
            if (c == 4) i_pmem_read = 1'b0;
        end

        // Ties where the winner drops after service: D first every round.
        fixed_lat = 1;
        for (int r = 0; r < 4; r++) begin
            i_pmem_read = 1'b1;
            d_pmem_read = 1'b1;
            d_pmem_address = 32'h8000_0040;
            collect(2, 1'b1, seq);
            chki("tie_round_order", seq, 6);
        end

        // Both requesters hold continuously: fixed priority starves I, round-robin alternates.
        i_pmem_read = 1'b1;
        d_pmem_read = 1'b1;
        collect(4, 1'b0, seq);
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        chki("tie_hold_order", seq, RR ? 102 : 85);
        next_cycle();

        // Write-back then fill of the same line; requester bus changes mid-grant.
        fixed_lat = 3;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h8000_0080;
        d_pmem_wdata = pat_a5;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            if (c == 2) begin
                d_pmem_address = 32'hDEAD_0000;
                d_pmem_wdata = '0;
            end
            @(negedge clk);
            chk1("wb_mem_write", mem_write, 1'b1);
            chk1("wb_mem_read", mem_read, 1'b0);
            chka("wb_addr_held", mem_address, 32'h8000_0080);
            chkl("wb_wdata_held", mem_wdata, pat_a5);
            chk1("wb_d_resp", d_pmem_resp, (c == 4));
        end
        next_cycle();
        d_pmem_write = 1'b0;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h8000_0080;
        next_cycle();
        @(negedge clk);
        chk1("fill_mem_read", mem_read, 1'b1);
        chk1("fill_mem_write", mem_write, 1'b0);
        chka("fill_addr", mem_address, 32'h8000_0080);
        next_cycle();
        collect(1, 1'b1, seq);
        chki("fill_order", seq, 1);

        // Reset in the middle of a write-back.
        fixed_lat = 20;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h8000_0100;
        d_pmem_wdata = {8{$urandom}};
        next_cycle();
        @(negedge clk);
        chk1("rst_mid_pre_write", mem_write, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("rst_mid_write", mem_write, 1'b0);
        chk1("rst_mid_read", mem_read, 1'b0);
        chk1("rst_mid_d_resp", d_pmem_resp, 1'b0);
        chka("rst_mid_addr", mem_address, 32'h0);
        d_pmem_write = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_after_write", mem_write, 1'b0);
        next_cycle();

        // Spurious memory response while idle, then combined read+write.
        resp_mode = 2;
        mem_resp = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            chk1("spur_i_resp", i_pmem_resp, 1'b0);
            chk1("spur_d_resp", d_pmem_resp, 1'b0);
            chk1("spur_mem_read", mem_read, 1'b0);
        end
        mem_resp = 1'b0;
        resp_mode = 0;
        fixed_lat = 2;
        next_cycle();
        d_pmem_read = 1'b1;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h8000_0200;
        next_cycle();
        @(negedge clk);
        chk1("rw_mem_write", mem_write, 1'b1);
        chk1("rw_mem_read", mem_read, 1'b0);
        next_cycle();
        collect(1, 1'b1, seq);
        chki("rw_order", seq, 1);

        // Randomized traffic, spurious responses and occasional asynchronous reset pulses.
        resp_mode = 1;
        rand_lat = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            next_cycle();
            mem_rdata = {8{$urandom}};
            if (($urandom % 4) == 0) i_pmem_read = ($urandom % 2) == 1;
            if (($urandom % 4) == 0) d_pmem_read = ($urandom % 2) == 1;
            if (($urandom % 5) == 0) d_pmem_write = ($urandom % 3) == 0;
            if (($urandom % 3) == 0) i_pmem_address = $urandom;
            if (($urandom % 3) == 0) d_pmem_address = $urandom;
            if (($urandom % 3) == 0) d_pmem_wdata = {8{$urandom}};
            if (($urandom % 400) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        resp_mode = 0;
        rand_lat = 1'b0;
        fixed_lat = 1;
        repeat (10) next_cycle();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
